// File: rtl/dmshr_refill_resp_pkg.sv
// Shared dcache definitions for the MSHR refill responder: sizing defaults and FSM encoding.
package dmshr_refill_resp_pkg;

  // Physical address width; stands in for the project-wide address range.
  localparam int unsigned PADDR_W = 40;

  localparam int unsigned DEF_MSHR_NUM = 4;
  localparam int unsigned DEF_BEAT_W   = 64;
  localparam int unsigned DEF_LINE_W   = 512;

  localparam int unsigned BEATS = DEF_LINE_W / DEF_BEAT_W;
  localparam int unsigned ID_W  = $clog2(DEF_MSHR_NUM);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StData,
    StResp
  } refill_state_e;

endpackage

// File: rtl/dmshr_refill_resp.sv
// Serves one MSHR refill at a time: issues a line read, assembles the beats into a line,
// and returns a single-cycle response tagged with the MSHR id and a beat-count error flag.
module dmshr_refill_resp
  import dmshr_refill_resp_pkg::*;
#(
  parameter int unsigned MSHR_NUM = DEF_MSHR_NUM,
  parameter int unsigned BEAT_W   = DEF_BEAT_W,
  parameter int unsigned LINE_W   = DEF_LINE_W
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        dmshr2arb_valid,
  output logic                        dmshr2arb_ready,
  input  logic [PADDR_W-1:0]          dmshr2arb_paddr,
  input  logic [$clog2(MSHR_NUM)-1:0] dmshr2arb_id,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [PADDR_W-1:0]          mem_req_addr,
  input  logic                        mem_rdata_valid,
  input  logic [BEAT_W-1:0]           mem_rdata,
  input  logic                        mem_rdata_last,
  output logic                        chi_arb_resp_valid,
  output logic [$clog2(MSHR_NUM)-1:0] chi_arb_resp_id,
  output logic [LINE_W-1:0]           chi_arb_resp_data,
  output logic                        chi_arb_resp_err
);

  localparam int unsigned NumBeats = LINE_W / BEAT_W;
  localparam int unsigned CntW     = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam int unsigned IdW      = $clog2(MSHR_NUM);
  localparam logic [CntW-1:0] LastCnt = CntW'(NumBeats - 1);
  localparam logic [PADDR_W-1:0] OffMask = PADDR_W'(LINE_W / 8 - 1);

  refill_state_e state_q, state_d;

  logic [PADDR_W-1:0] addr_q;
  logic [IdW-1:0]     id_q;
  logic [CntW-1:0]    cnt_q;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [IdW-1:0]     resp_id_q;
  logic [LINE_W-1:0]  resp_data_q;
  logic               err_q, err_d;

  logic accept;
  logic beat;
  logic final_beat;

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    beat       = 1'b0;
    final_beat = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dmshr2arb_valid) begin
          accept  = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (mem_req_ready) begin
          state_d = StData;
        end
      end
      StData: begin
        if (mem_rdata_valid) begin
          beat = 1'b1;
          if (mem_rdata_last || (cnt_q == LastCnt)) begin
            final_beat = 1'b1;
            state_d    = StResp;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    line_d = line_q;
    line_d[cnt_q*BEAT_W +: BEAT_W] = mem_rdata;
  end

  // Error whenever "last" and "counter full" disagree on where the line ends.
  assign err_d = mem_rdata_last ^ (cnt_q == LastCnt);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      line_q      <= '0;
      resp_id_q   <= '0;
      resp_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= dmshr2arb_paddr & ~OffMask;
        id_q   <= dmshr2arb_id;
        line_q <= '0;
        cnt_q  <= '0;
      end
      if (beat) begin
        line_q <= line_d;
        cnt_q  <= cnt_q + CntW'(1);
      end
      // Response registers load only at the end of a line so they hold between refills.
      if (final_beat) begin
        resp_data_q <= line_d;
        resp_id_q   <= id_q;
        err_q       <= err_d;
      end
    end
  end

  assign dmshr2arb_ready    = (state_q == StIdle);
  assign mem_req_valid      = (state_q == StReq);
  assign mem_req_addr       = addr_q;
  assign chi_arb_resp_valid = (state_q == StResp);
  assign chi_arb_resp_id    = resp_id_q;
  assign chi_arb_resp_data  = resp_data_q;
  assign chi_arb_resp_err   = (state_q == StResp) && err_q;

endmodule

// File: tb/tb_dmshr_refill_resp.sv
// Directed bench for dmshr_refill_resp: normal, back-pressured, early/missing last,
// busy/stray traffic and mid-transaction reset.
module tb_dmshr_refill_resp;
  import dmshr_refill_resp_pkg::*;

  localparam int unsigned LW = 512;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               dmshr2arb_valid;
  logic               dmshr2arb_ready;
  logic [PADDR_W-1:0] dmshr2arb_paddr;
  logic [1:0]         dmshr2arb_id;
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [PADDR_W-1:0] mem_req_addr;
  logic               mem_rdata_valid;
  logic [63:0]        mem_rdata;
  logic               mem_rdata_last;
  logic               chi_arb_resp_valid;
  logic [1:0]         chi_arb_resp_id;
  logic [LW-1:0]      chi_arb_resp_data;
  logic               chi_arb_resp_err;

  int checks = 0;
  int errors = 0;

  dmshr_refill_resp #(
    .MSHR_NUM(4),
    .BEAT_W  (64),
    .LINE_W  (512)
  ) u_dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .dmshr2arb_valid   (dmshr2arb_valid),
    .dmshr2arb_ready   (dmshr2arb_ready),
    .dmshr2arb_paddr   (dmshr2arb_paddr),
    .dmshr2arb_id      (dmshr2arb_id),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_addr      (mem_req_addr),
    .mem_rdata_valid   (mem_rdata_valid),
    .mem_rdata         (mem_rdata),
    .mem_rdata_last    (mem_rdata_last),
    .chi_arb_resp_valid(chi_arb_resp_valid),
    .chi_arb_resp_id   (chi_arb_resp_id),
    .chi_arb_resp_data (chi_arb_resp_data),
    .chi_arb_resp_err  (chi_arb_resp_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // last_beat: 1-based beat carrying last (0 = never). The line ends at that beat or beat 8.
  task automatic refill(input string name, input logic [PADDR_W-1:0] pa, input logic [1:0] rid,
                        input int stall, input int last_beat, input bit busy,
                        input logic [PADDR_W-1:0] exp_addr, input logic exp_err);
    logic [LW-1:0] exp_line;
    int            nb;
    exp_line = '0;
    nb = (last_beat == 0 || last_beat > 8) ? 8 : last_beat;
    dmshr2arb_valid = 1'b1;
    dmshr2arb_paddr = pa;
    dmshr2arb_id    = rid;
    tick();
    dmshr2arb_valid = 1'b0;
    dmshr2arb_paddr = '0;
    dmshr2arb_id    = '0;
    check({name, ".req_valid"}, mem_req_valid, 1);
    check({name, ".req_addr"}, mem_req_addr, exp_addr);
    check({name, ".ready_busy"}, dmshr2arb_ready, 0);
    for (int s = 0; s < stall; s++) begin
      // Beats arriving before the handshake must not land in the line.
      mem_rdata_valid = 1'b1;
      mem_rdata       = 64'hdead_beef_0000_0000 | 64'(s);
      mem_rdata_last  = 1'b1;
      tick();
      check({name, ".stall_valid"}, mem_req_valid, 1);
      check({name, ".stall_addr"}, mem_req_addr, exp_addr);
      check({name, ".stall_resp"}, chi_arb_resp_valid, 0);
    end
    mem_rdata_valid = 1'b0;
    mem_rdata_last  = 1'b0;
    mem_req_ready   = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check({name, ".req_done"}, mem_req_valid, 0);
    for (int i = 0; i < nb; i++) begin
      if (busy) begin
        dmshr2arb_valid = 1'b1;
        dmshr2arb_paddr = 40'h00_9999_0000;
      end
      mem_rdata_valid = 1'b1;
      mem_rdata       = 64'h11 * 64'(i + 1);
      mem_rdata_last  = (i + 1 == last_beat);
      exp_line[i*64 +: 64] = 64'h11 * 64'(i + 1);
      tick();
      check({name, ".resp_valid"}, chi_arb_resp_valid, (i == nb - 1) ? 1 : 0);
      check({name, ".ready_data"}, dmshr2arb_ready, 0);
    end
    mem_rdata_valid = 1'b0;
    mem_rdata_last  = 1'b0;
    check({name, ".resp_id"}, chi_arb_resp_id, rid);
    check({name, ".resp_data"}, chi_arb_resp_data, exp_line);
    check({name, ".resp_err"}, chi_arb_resp_err, exp_err);
    tick();
    dmshr2arb_valid = 1'b0;
    dmshr2arb_paddr = '0;
    check({name, ".resp_gone"}, chi_arb_resp_valid, 0);
    check({name, ".err_gone"}, chi_arb_resp_err, 0);
    check({name, ".ready_back"}, dmshr2arb_ready, 1);
    check({name, ".data_hold"}, chi_arb_resp_data, exp_line);
    check({name, ".id_hold"}, chi_arb_resp_id, rid);
  endtask

  initial begin
    reset_n         = 1'b0;
    dmshr2arb_valid = 1'b0;
    dmshr2arb_paddr = '0;
    dmshr2arb_id    = '0;
    mem_req_ready   = 1'b0;
    mem_rdata_valid = 1'b0;
    mem_rdata       = '0;
    mem_rdata_last  = 1'b0;
    #12;
    check("rst.req_valid", mem_req_valid, 0);
    check("rst.resp_valid", chi_arb_resp_valid, 0);
    check("rst.resp_err", chi_arb_resp_err, 0);
    check("rst.req_addr", mem_req_addr, 0);
    check("rst.resp_id", chi_arb_resp_id, 0);
    check("rst.resp_data", chi_arb_resp_data, 0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check("rst.ready", dmshr2arb_ready, 1);

    refill("norm", 40'h00_8000_1234, 2'd2, 0, 8, 1'b0, 40'h00_8000_1200, 1'b0);
    refill("bp", 40'h00_8000_2040, 2'd1, 5, 8, 1'b0, 40'h00_8000_2040, 1'b0);
    refill("early", 40'h00_8000_307f, 2'd3, 0, 3, 1'b0, 40'h00_8000_3040, 1'b1);
    refill("nolast", 40'h00_0000_0fff, 2'd0, 0, 0, 1'b0, 40'h00_0000_0fc0, 1'b1);
    refill("busy", 40'h00_8000_5008, 2'd1, 0, 8, 1'b1, 40'h00_8000_5000, 1'b0);

    // Stray beats while idle.
    for (int k = 0; k < 3; k++) begin
      mem_rdata_valid = 1'b1;
      mem_rdata       = 64'hffff_ffff_ffff_ffff;
      mem_rdata_last  = 1'b1;
      tick();
      check("stray.resp_valid", chi_arb_resp_valid, 0);
      check("stray.ready", dmshr2arb_ready, 1);
      check("stray.req_valid", mem_req_valid, 0);
    end
    mem_rdata_valid = 1'b0;
    mem_rdata_last  = 1'b0;

    // Reset after four beats of a refill.
    dmshr2arb_valid = 1'b1;
    dmshr2arb_paddr = 40'h00_8000_4000;
    dmshr2arb_id    = 2'd1;
    tick();
    dmshr2arb_valid = 1'b0;
    mem_req_ready   = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rdata_valid = 1'b1;
      mem_rdata       = 64'h11 * 64'(i + 1);
      tick();
    end
    mem_rdata_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("mrst.ready", dmshr2arb_ready, 1);
    check("mrst.resp_valid", chi_arb_resp_valid, 0);
    check("mrst.req_valid", mem_req_valid, 0);
    check("mrst.resp_data", chi_arb_resp_data, 0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mrst.no_resp", chi_arb_resp_valid, 0);
      check("mrst.idle", dmshr2arb_ready, 1);
    end
    refill("post", 40'h00_8000_1234, 2'd2, 0, 8, 1'b0, 40'h00_8000_1200, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
